dec_stage_pipe: RTL
===================

Name: dec_stage_pipe

Overview:
Parametrised, pipelined MIPS decode stage. Reads two operands from an internal 2-read/1-write register file with write-through bypass and extends the 16-bit immediate in one of four modes. Registers decoded results into an ID/EX output register with valid/stall/flush control. Sits between the fetch stage and the execute stage; the write-back stage drives the write port.

Parameters:
DATA_W, 32, operand/immediate/register width (>= 32)
REG_CNT, 32, number of registers; power of two, 2..32; AW = clog2(REG_CNT)

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
Instr  input  32  instruction word from fetch
In_valid  input  1  Instr is valid this cycle
Stall  input  1  hold output register contents
Flush  input  1  invalidate output register (bubble)
RF_B_sel  input  1  read-port-2 address: 0 = Instr[15:11], 1 = Instr[20:16]
Imm_sel  input  2  immediate mode: 00 zero-ext, 01 sign-ext, 10 imm<<16, 11 sign-ext<<2
RF_WrEn  input  1  register-file write enable from write-back
RF_WrAddr  input  AW  write address from write-back
RF_WrData_sel  input  1  write data: 0 = ALU_out, 1 = MEM_out
ALU_out  input  DATA_W  write-back candidate
MEM_out  input  DATA_W  write-back candidate
Out_valid  output  1  output register holds a valid decoded instruction
Immed  output  DATA_W  registered extended immediate
RF_A  output  DATA_W  registered operand A (rs)
RF_B  output  DATA_W  registered operand B
Src_A_addr  output  AW  registered rs address, for the hazard unit
Src_B_addr  output  AW  registered read-port-2 address, for the hazard unit

Behaviour:
- Reset (async, any time, including mid-stall): all register-file entries = 0; Out_valid, Immed, RF_A, RF_B, Src_A_addr, Src_B_addr = 0. Reset overrides every other event.
- Address fields:
  - rs = Instr[25:21], rt = Instr[20:16], rd = Instr[15:11].
  - Each field is truncated to its low AW bits.
- Register-file write:
  - At posedge when RF_WrEn=1 and RF_WrAddr != 0.
  - WrData = RF_WrData_sel ? MEM_out : ALU_out.
  - Register 0 always reads 0 and writes to it are ignored.
- Register-file read: combinational, with write-through bypass. If RF_WrEn=1, RF_WrAddr == read address, and the address != 0, the read returns WrData in the same cycle.
- Immediate (imm = Instr[15:0]):
  - 00: zero-extend to DATA_W.
  - 01: sign-extend to DATA_W.
  - 10: {imm, 16'b0}, zero-extended to DATA_W.
  - 11: sign-extend, then shift left by 2 (upper bits discarded).
- Output register, priority Flush > Stall > load, evaluated at each posedge:
  - Flush=1: Out_valid <= 0 and all data/address outputs <= 0. Applies even if Stall=1.
  - Stall=1 and Flush=0: all outputs hold, with one exception (stall refresh). If RF_WrEn=1, RF_WrAddr != 0, and RF_WrAddr == Src_A_addr, then RF_A <= WrData. The same rule applies to RF_B with Src_B_addr. Both may refresh in the same cycle. Refresh occurs whether or not Out_valid=1.
  - Otherwise (load): Out_valid <= In_valid. Immed, RF_A, RF_B, Src_A_addr, and Src_B_addr take this cycle's decoded and bypassed values. Data is loaded even when In_valid=0; the stage treats it as don't-care.
- Latency: exactly 1 cycle from Instr to outputs, including a same-cycle write-back value via the bypass.
- Throughput: 1 instruction per cycle when Stall=0.

Decomposition:
- Package dec_pkg holds:
  - Imm_sel codes: IMM_ZERO=2'b00, IMM_SIGN=2'b01, IMM_UPPER=2'b10, IMM_BRANCH=2'b11.
  - Field bit positions: RS_HI/LO, RT_HI/LO, RD_HI/LO, IMM_HI/LO.
- One sub-module, rf_2r1w: the parametrised (DATA_W, REG_CNT) register file with async reset, r0 hardwiring, and write-through bypass.
- The immediate extender and the output register stay in dec_stage_pipe.

Test Plan:
- Reset, then write r5 = 32'h1234_5678 (RF_WrEn=1, RF_WrData_sel=0). Next cycle, decode rs=5 -> RF_A=32'h1234_5678 one cycle after the decode.
- Same cycle: write r7 = MEM_out 32'hDEAD_BEEF and decode rs=7, rt=7, RF_B_sel=1 -> next cycle RF_A = RF_B = 32'hDEAD_BEEF (bypass). A write to r0 followed by a read of r0 -> 0.
- Immediate 16'h8001 under each mode:
  - 00 -> 32'h0000_8001
  - 01 -> 32'hFFFF_8001
  - 10 -> 32'h8001_0000
  - 11 -> 32'hFFFE_0004
- Decode rs=3 with r3=10, assert Stall for 3 cycles, and write r3=20 during the stall -> RF_A updates to 20 while the other outputs hold. Deassert Stall -> the next instruction loads.
- Stall=1 and Flush=1 together -> Out_valid=0 and outputs=0. Assert Reset asynchronously mid-stall -> all outputs 0 immediately, and a later read of r5 returns 0.
- REG_CNT=8 instance: rs field 5'b11010 addresses r2, and writes/reads to r2 round-trip correctly.

Source files
------------

// File: rtl/dec_pkg.sv
// Shared constants for the decode stage: immediate mode codes and
// instruction field bit positions.
package dec_pkg;

  typedef enum logic [1:0] {
    IMM_ZERO   = 2'b00,
    IMM_SIGN   = 2'b01,
    IMM_UPPER  = 2'b10,
    IMM_BRANCH = 2'b11
  } imm_sel_e;

  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

endpackage

// File: rtl/dec_stage_pipe_if.sv
// Handshake/bus bundle between fetch, write-back and the decode stage.
// master = environment side, slave = decode stage side.
interface dec_stage_pipe_if #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32,
  parameter int AW      = $clog2(REG_CNT)
);

  logic [31:0]       Instr;
  logic              In_valid;
  logic              Stall;
  logic              Flush;
  logic              RF_B_sel;
  logic [1:0]        Imm_sel;
  logic              RF_WrEn;
  logic [AW-1:0]     RF_WrAddr;
  logic              RF_WrData_sel;
  logic [DATA_W-1:0] ALU_out;
  logic [DATA_W-1:0] MEM_out;

  logic              Out_valid;
  logic [DATA_W-1:0] Immed;
  logic [DATA_W-1:0] RF_A;
  logic [DATA_W-1:0] RF_B;
  logic [AW-1:0]     Src_A_addr;
  logic [AW-1:0]     Src_B_addr;

  modport master (
    output Instr, In_valid, Stall, Flush, RF_B_sel, Imm_sel,
           RF_WrEn, RF_WrAddr, RF_WrData_sel, ALU_out, MEM_out,
    input  Out_valid, Immed, RF_A, RF_B, Src_A_addr, Src_B_addr
  );

  modport slave (
    input  Instr, In_valid, Stall, Flush, RF_B_sel, Imm_sel,
           RF_WrEn, RF_WrAddr, RF_WrData_sel, ALU_out, MEM_out,
    output Out_valid, Immed, RF_A, RF_B, Src_A_addr, Src_B_addr
  );

endinterface

// File: rtl/dec_stage_pipe_rf.sv
// 2-read/1-write register file. r0 is hardwired to zero; reads see a
// same-cycle write (write-through bypass) so decode never waits on WB.
module rf_2r1w #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32,
  parameter int AW      = $clog2(REG_CNT)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_a_i,
  input  logic [AW-1:0]     raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] mem_q [REG_CNT];
  logic              wr_ok;

  assign wr_ok = we_i && (waddr_i != '0);

  // Storage: cleared on reset, r0 never written.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < REG_CNT; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports with bypass of the in-flight write.
  always_comb begin
    rdata_a_o = '0;
    rdata_b_o = '0;
    if (raddr_a_i != '0) rdata_a_o = (wr_ok && waddr_i == raddr_a_i) ? wdata_i : mem_q[raddr_a_i];
    if (raddr_b_i != '0) rdata_b_o = (wr_ok && waddr_i == raddr_b_i) ? wdata_i : mem_q[raddr_b_i];
  end

endmodule

// File: rtl/dec_stage_pipe.sv
// MIPS decode stage: operand read with bypass, immediate extension and
// the ID/EX output register (Flush > Stall > load).
module dec_stage_pipe
  import dec_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32,
  parameter int AW      = $clog2(REG_CNT)
) (
  input logic           Clk,
  input logic           Reset,
  dec_stage_pipe_if.slave bus
);

  logic [4:0]        rs_f, rt_f, rd_f;
  logic [AW-1:0]     rs, rb;
  logic [15:0]       imm;
  logic [DATA_W-1:0] imm_sx, imm_ext;
  logic [DATA_W-1:0] wr_data, rd_a, rd_b;
  logic              unused_fields;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] immed_q, immed_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [AW-1:0]     sa_q, sa_d;
  logic [AW-1:0]     sb_q, sb_d;

  assign rs_f = bus.Instr[RS_HI:RS_LO];
  assign rt_f = bus.Instr[RT_HI:RT_LO];
  assign rd_f = bus.Instr[RD_HI:RD_LO];
  assign imm  = bus.Instr[IMM_HI:IMM_LO];

  // Opcode and any address bits above AW are not used by this stage.
  assign unused_fields = ^{bus.Instr[31:26], rs_f, rt_f, rd_f};

  assign rs      = rs_f[AW-1:0];
  assign rb      = bus.RF_B_sel ? rt_f[AW-1:0] : rd_f[AW-1:0];
  assign wr_data = bus.RF_WrData_sel ? bus.MEM_out : bus.ALU_out;

  rf_2r1w #(.DATA_W(DATA_W), .REG_CNT(REG_CNT), .AW(AW)) u_rf (
    .clk_i     (Clk),
    .rst_i     (Reset),
    .we_i      (bus.RF_WrEn),
    .waddr_i   (bus.RF_WrAddr),
    .wdata_i   (wr_data),
    .raddr_a_i (rs),
    .raddr_b_i (rb),
    .rdata_a_o (rd_a),
    .rdata_b_o (rd_b)
  );

  assign imm_sx = {{(DATA_W-16){imm[15]}}, imm};

  // Immediate extension in the four supported modes.
  always_comb begin
    imm_ext = '0;
    case (imm_sel_e'(bus.Imm_sel))
      IMM_ZERO:   imm_ext = {{(DATA_W-16){1'b0}}, imm};
      IMM_SIGN:   imm_ext = imm_sx;
      IMM_UPPER:  imm_ext = {{(DATA_W-16){1'b0}}, imm} << 16;
      IMM_BRANCH: imm_ext = imm_sx << 2;
      default:    imm_ext = '0;
    endcase
  end

  // Output register next state. While stalled, a write-back to a held
  // source register refreshes that operand so EX never sees a stale value.
  always_comb begin
    valid_d = valid_q;
    immed_d = immed_q;
    a_d     = a_q;
    b_d     = b_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    if (bus.Flush) begin
      valid_d = 1'b0;
      immed_d = '0;
      a_d     = '0;
      b_d     = '0;
      sa_d    = '0;
      sb_d    = '0;
    end else if (bus.Stall) begin
      if (bus.RF_WrEn && bus.RF_WrAddr != '0) begin
        if (bus.RF_WrAddr == sa_q) a_d = wr_data;
        if (bus.RF_WrAddr == sb_q) b_d = wr_data;
      end
    end else begin
      valid_d = bus.In_valid;
      immed_d = imm_ext;
      a_d     = rd_a;
      b_d     = rd_b;
      sa_d    = rs;
      sb_d    = rb;
    end
  end

  // ID/EX register with asynchronous reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      valid_q <= 1'b0;
      immed_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
    end else begin
      valid_q <= valid_d;
      immed_q <= immed_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
    end
  end

  assign bus.Out_valid  = valid_q;
  assign bus.Immed      = immed_q;
  assign bus.RF_A       = a_q;
  assign bus.RF_B       = b_q;
  assign bus.Src_A_addr = sa_q;
  assign bus.Src_B_addr = sb_q;

endmodule
